// File: rtl/stream_merge2x1.sv
// stream_merge2x1
// Merges two valid/ready packet streams (X and Y) into one registered output
// stream (M). The grant is round-robin per packet: once a source wins the
// first beat of a packet, it keeps the grant until its last beat is accepted.
// Because of this, packets from X and Y never interleave on M.
//
// Ports:
//   clk, reset               - clock and synchronous active-high reset
//   x_data/x_last/x_valid    - X input beat; x_ready accepts it
//   y_data/y_last/y_valid    - Y input beat; y_ready accepts it
//   m_data/m_last/m_valid    - registered merged output beat
//   m_ready                  - downstream accept for the output beat
//   sel                      - source of the beat held in the output
//                              register (0 = X, 1 = Y)
module stream_merge2x1 #(
    parameter int dataW = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [dataW-1:0] x_data,
    input  logic             x_last,
    input  logic             x_valid,
    output logic             x_ready,
    input  logic [dataW-1:0] y_data,
    input  logic             y_last,
    input  logic             y_valid,
    output logic             y_ready,
    output logic [dataW-1:0] m_data,
    output logic             m_last,
    output logic             m_valid,
    input  logic             m_ready,
    output logic             sel
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOCK_X = 2'd1,
        LOCK_Y = 2'd2
    } state_t;

    state_t           r_state;
    logic             r_prio;
    logic [dataW-1:0] r_mData;
    logic             r_mLast;
    logic             r_mValid;
    logic             r_sel;

    logic             w_load;
    logic             w_grantY;
    logic             w_xAcc;
    logic             w_yAcc;

    // The output register can take a new beat when it is empty, or when its
    // current beat is being drained in this same cycle.
    assign w_load   = ~r_mValid | m_ready;

    // Idle arbitration: a lone requester wins. On a tie, the priority bit
    // decides, and that bit points away from whichever source finished the
    // most recent packet.
    assign w_grantY = y_valid & (~x_valid | r_prio);

    // While a source is locked, its ready follows only the output load. The
    // other source is ignored completely until the packet completes.
    assign x_ready  = w_load & (((r_state == IDLE) & ~w_grantY & x_valid) | (r_state == LOCK_X));
    assign y_ready  = w_load & (((r_state == IDLE) &  w_grantY & y_valid) | (r_state == LOCK_Y));

    assign w_xAcc   = x_valid & x_ready;
    assign w_yAcc   = y_valid & y_ready;

    // Main state machine plus output register.
    // An accepted beat always overwrites the output register. A beat without
    // last that starts a packet moves into the lock state for its source.
    // A last beat returns to IDLE and hands tie priority to the other source.
    // If nothing is accepted and downstream takes the beat, only m_valid
    // drops; data, last and sel keep their previous values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= IDLE;
            r_prio   <= 1'b0;
            r_mData  <= '0;
            r_mLast  <= 1'b0;
            r_mValid <= 1'b0;
            r_sel    <= 1'b0;
        end else if (w_xAcc) begin
            r_mData  <= x_data;
            r_mLast  <= x_last;
            r_mValid <= 1'b1;
            r_sel    <= 1'b0;
            if (x_last) begin
                r_state <= IDLE;
                r_prio  <= 1'b1;
            end else if (r_state == IDLE) begin
                r_state <= LOCK_X;
            end
        end else if (w_yAcc) begin
            r_mData  <= y_data;
            r_mLast  <= y_last;
            r_mValid <= 1'b1;
            r_sel    <= 1'b1;
            if (y_last) begin
                r_state <= IDLE;
                r_prio  <= 1'b0;
            end else if (r_state == IDLE) begin
                r_state <= LOCK_Y;
            end
        end else if (m_ready) begin
            r_mValid <= 1'b0;
        end
    end

    assign m_data  = r_mData;
    assign m_last  = r_mLast;
    assign m_valid = r_mValid;
    assign sel     = r_sel;

endmodule

// File: tb/tb_stream_merge2x1.sv
// tb_stream_merge2x1
// Directed bench for stream_merge2x1. Inputs are driven 1 ns after each rising
// edge. Combinational readys are checked 1 ns after that. Registered outputs
// are checked 1 ns after the edge that loaded them.
// Expected values are the hand-derived results of each step.
module tb_stream_merge2x1;

    logic       clk;
    logic       reset;
    logic [7:0] x_data;
    logic       x_last;
    logic       x_valid;
    logic       x_ready;
    logic [7:0] y_data;
    logic       y_last;
    logic       y_valid;
    logic       y_ready;
    logic [7:0] m_data;
    logic       m_last;
    logic       m_valid;
    logic       m_ready;
    logic       sel;

    int checks;
    int errors;

    stream_merge2x1 #(.dataW(8)) dut (
        .clk     (clk),
        .reset   (reset),
        .x_data  (x_data),
        .x_last  (x_last),
        .x_valid (x_valid),
        .x_ready (x_ready),
        .y_data  (y_data),
        .y_last  (y_last),
        .y_valid (y_valid),
        .y_ready (y_ready),
        .m_data  (m_data),
        .m_last  (m_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .sel     (sel)
    );

    // 10 ns clock period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive every data-path input in one call.
    task automatic applyStimulus(input logic xv, input logic [7:0] xd, input logic xl,
                                 input logic yv, input logic [7:0] yd, input logic yl,
                                 input logic mr);
        x_valid = xv;
        x_data  = xd;
        x_last  = xl;
        y_valid = yv;
        y_data  = yd;
        y_last  = yl;
        m_ready = mr;
    endtask

    // One comparison: count it, and report it if it does not match.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance past the next rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0;
        errors = 0;

        // Reset for two edges while both sources present beats.
        reset = 1'b1;
        applyStimulus(1'b1, 8'h11, 1'b1, 1'b1, 8'h22, 1'b1, 1'b1);
        tick;
        tick;
        checkOutput("rst_mvalid", 32'(m_valid), 32'd0);
        checkOutput("rst_mdata",  32'(m_data),  32'h00);
        checkOutput("rst_sel",    32'(sel),     32'd0);
        checkOutput("rst_mlast",  32'(m_last),  32'd0);
        reset = 1'b0;
        #1;
        checkOutput("rst_tie_xready", 32'(x_ready), 32'd1);
        checkOutput("rst_tie_yready", 32'(y_ready), 32'd0);

        // Alternating ties between single-beat packets.
        for (int i = 0; i < 4; i++) begin
            tick;
            checkOutput("alt_mdata",  32'(m_data),  (i % 2 == 0) ? 32'h11 : 32'h22);
            checkOutput("alt_sel",    32'(sel),     (i % 2 == 0) ? 32'd0 : 32'd1);
            checkOutput("alt_mvalid", 32'(m_valid), 32'd1);
        end
        // Priority now points to X again.

        // Packet lock: a three-beat X packet, with Y waiting throughout.
        applyStimulus(1'b1, 8'hA0, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1);
        #1;
        checkOutput("lock_xready0", 32'(x_ready), 32'd1);
        checkOutput("lock_yready0", 32'(y_ready), 32'd0);
        tick;
        checkOutput("lock_a0", 32'(m_data), 32'hA0);
        applyStimulus(1'b1, 8'hA1, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1);
        #1;
        checkOutput("lock_yready1", 32'(y_ready), 32'd0);
        tick;
        checkOutput("lock_a1", 32'(m_data), 32'hA1);
        applyStimulus(1'b1, 8'hA2, 1'b1, 1'b1, 8'hB0, 1'b1, 1'b1);
        #1;
        checkOutput("lock_yready2", 32'(y_ready), 32'd0);
        tick;
        checkOutput("lock_a2",      32'(m_data), 32'hA2);
        checkOutput("lock_a2_last", 32'(m_last), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hB0, 1'b1, 1'b1);
        #1;
        checkOutput("lock_yready3", 32'(y_ready), 32'd1);
        tick;
        checkOutput("lock_b0",     32'(m_data),  32'hB0);
        checkOutput("lock_b0_sel", 32'(sel),     32'd1);
        checkOutput("lock_b0_vld", 32'(m_valid), 32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick;
        checkOutput("drain_mvalid", 32'(m_valid), 32'd0);
        checkOutput("drain_mdata",  32'(m_data),  32'hB0);

        // Backpressure: hold C1 in the output register for four cycles.
        applyStimulus(1'b1, 8'hC1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tick;
        checkOutput("bp_c1", 32'(m_data), 32'hC1);
        applyStimulus(1'b1, 8'hC2, 1'b1, 1'b1, 8'hD1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            #1;
            checkOutput("bp_xready", 32'(x_ready), 32'd0);
            checkOutput("bp_yready", 32'(y_ready), 32'd0);
            tick;
            checkOutput("bp_hold_data",  32'(m_data),  32'hC1);
            checkOutput("bp_hold_sel",   32'(sel),     32'd0);
            checkOutput("bp_hold_valid", 32'(m_valid), 32'd1);
        end
        // Release: C1 drains as D1 loads in the same cycle (Y has priority).
        m_ready = 1'b1;
        tick;
        checkOutput("bp_d1",       32'(m_data),  32'hD1);
        checkOutput("bp_d1_sel",   32'(sel),     32'd1);
        checkOutput("bp_d1_valid", 32'(m_valid), 32'd1);
        applyStimulus(1'b1, 8'hC2, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        tick;
        checkOutput("bp_c2",     32'(m_data), 32'hC2);
        checkOutput("bp_c2_sel", 32'(sel),    32'd0);

        // Reset mid-packet: after beat 2 of a four-beat X packet.
        applyStimulus(1'b1, 8'hE0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick;
        checkOutput("mid_e0", 32'(m_data), 32'hE0);
        applyStimulus(1'b1, 8'hE1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick;
        checkOutput("mid_e1", 32'(m_data), 32'hE1);
        reset = 1'b1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
        tick;
        reset = 1'b0;
        checkOutput("mid_mvalid", 32'(m_valid),    32'd0);
        checkOutput("mid_mdata",  32'(m_data),     32'h00);
        checkOutput("mid_prio",   32'(dut.r_prio), 32'd0);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b1);
        #1;
        checkOutput("mid_yready", 32'(y_ready), 32'd1);
        tick;
        checkOutput("mid_f0",     32'(m_data), 32'hF0);
        checkOutput("mid_f0_sel", 32'(sel),    32'd1);
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'hF1, 1'b1, 1'b1);
        tick;
        checkOutput("mid_f1", 32'(m_data), 32'hF1);

        // Single source: only Y valid while the priority bit already favours X.
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b1, 8'h55, 1'b1, 1'b1);
        #1;
        checkOutput("single_yready", 32'(y_ready), 32'd1);
        checkOutput("single_xready", 32'(x_ready), 32'd0);
        tick;
        checkOutput("single_data", 32'(m_data), 32'h55);
        checkOutput("single_sel",  32'(sel),    32'd1);
        checkOutput("single_last", 32'(m_last), 32'd1);
        // After Y's last beat, a tie must go to X.
        applyStimulus(1'b1, 8'h66, 1'b1, 1'b1, 8'h77, 1'b1, 1'b1);
        #1;
        checkOutput("single_tie_xready", 32'(x_ready), 32'd1);
        checkOutput("single_tie_yready", 32'(y_ready), 32'd0);
        tick;
        checkOutput("single_tie_data", 32'(m_data), 32'h66);
        checkOutput("single_tie_sel",  32'(sel),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
